// File: rtl/bpm_bcd_formatter.sv
// bpm_bcd_formatter
//   Converts the metronome's binary BPM into three BCD digits and a packed
//   display word. It uses a sequential double-dabble engine that does one
//   shift-add-3 step per cycle. A conversion starts automatically whenever bpm
//   differs from the value last converted, and once after every reset.
//   Outputs are registered only in the final LOAD cycle, so they never show a
//   partially converted value.
//
// Ports
//   clk       system clock (100 MHz)
//   rst       synchronous, active-high reset
//   bpm       binary BPM from the metronome; may change on any cycle
//   disp_val  packed display word {4'd0, hundreds, tens, ones}
//   hundreds  BCD hundreds digit
//   tens      BCD tens digit
//   ones      BCD ones digit
//   blank     leading-zero blank mask {hundreds, tens, ones}; bit0 is always 0
//   busy      high while a conversion is in flight
//   update    one-cycle pulse when new digits are registered

// Add-3 correction for a single BCD scratch nibble. Each nibble is corrected
// on its own, and no carry passes between nibbles.
module bpm_bcd_adj3 (
  input  logic [3:0] nib,
  output logic [3:0] adj
);
  assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;
endmodule

module bpm_bcd_formatter #(
  parameter int BPM_W = 8,
  parameter int ITER  = 8   // shift count; must equal BPM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BPM_W-1:0] bpm,
  output logic [15:0]      disp_val,
  output logic [3:0]       hundreds,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic [2:0]       blank,
  output logic             busy,
  output logic             update
);

  localparam int NUM_DIG = 3;
  localparam int SCR_W   = 4 * NUM_DIG;
  localparam int CNT_W   = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

  state_t           state;
  logic [SCR_W-1:0] scratch;
  logic [SCR_W-1:0] scratch_adj;
  logic [BPM_W-1:0] shift_reg;
  logic [BPM_W-1:0] last_bpm;
  logic [CNT_W-1:0] iter_cnt;
  logic             pending;   // forces a conversion after reset, even for bpm == 0

  // Per-digit add-3 correction, applied before each shift.
  genvar g;
  generate
    for (g = 0; g < NUM_DIG; g++) begin : g_dig
      bpm_bcd_adj3 u_adj (
        .nib (scratch[4*g +: 4]),
        .adj (scratch_adj[4*g +: 4])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= 1'b1;
      last_bpm  <= '0;
      shift_reg <= '0;
      scratch   <= '0;
      iter_cnt  <= '0;
      disp_val  <= 16'd0;
      hundreds  <= 4'd0;
      tens      <= 4'd0;
      ones      <= 4'd0;
      blank     <= 3'b110;
      busy      <= 1'b0;
      update    <= 1'b0;
    end else begin
      update <= 1'b0;
      case (state)
        IDLE: begin
          if (pending || (bpm != last_bpm)) begin
            shift_reg <= bpm;
            last_bpm  <= bpm;
            scratch   <= '0;
            iter_cnt  <= '0;
            pending   <= 1'b0;
            busy      <= 1'b1;
            state     <= CONVERT;
          end else begin
            busy <= 1'b0;
          end
        end

        CONVERT: begin
          // Shift the corrected scratch and the remaining binary bits left as one word.
          {scratch, shift_reg} <= {scratch_adj[SCR_W-2:0], shift_reg, 1'b0};
          iter_cnt             <= iter_cnt + CNT_W'(1);
          if (iter_cnt == CNT_W'(ITER - 1))
            state <= LOAD;
        end

        LOAD: begin
          hundreds <= scratch[11:8];
          tens     <= scratch[7:4];
          ones     <= scratch[3:0];
          disp_val <= {4'd0, scratch};
          blank    <= {(scratch[11:8] == 4'd0),
                       (scratch[11:8] == 4'd0) && (scratch[7:4] == 4'd0),
                       1'b0};
          update   <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpm_bcd_formatter.sv
module tb_bpm_bcd_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  bpm;
  logic [15:0] disp_val;
  logic [3:0]  hundreds, tens, ones;
  logic [2:0]  blank;
  logic        busy, update;

  int total = 0;
  int bad   = 0;
  int both_hi = 0;

  always #5 clk = ~clk;

  bpm_bcd_formatter #(.BPM_W(8), .ITER(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bpm      (bpm),
    .disp_val (disp_val),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones),
    .blank    (blank),
    .busy     (busy),
    .update   (update)
  );

  // busy and update must never be high together.
  always @(negedge clk) if (busy === 1'b1 && update === 1'b1) both_hi++;

  typedef struct {
    logic [7:0]  bpm;
    logic [15:0] disp;
    logic [2:0]  blank;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model derived from decimal arithmetic.
  function automatic logic [15:0] ref_disp(input int b);
    return 16'(((b / 100) << 8) | (((b / 10) % 10) << 4) | (b % 10));
  endfunction

  function automatic logic [2:0] ref_blank(input int b);
    return {b < 100, b < 10, 1'b0};
  endfunction

  // Waits for the next update pulse (bounded). It reports the cycles taken and
  // whether disp_val held its value until the pulse.
  task automatic wait_upd(output int n, output bit ok, output bit held);
    logic [15:0] prev;
    prev = disp_val;
    n = 0; ok = 0; held = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (update) begin ok = 1; break; end
      if (disp_val !== prev) held = 0;
    end
  endtask

  // Drives v from idle and checks latency, digits, mask, and the single pulse.
  task automatic run_conv(input logic [7:0] v, input logic [15:0] ed,
                          input logic [2:0] eb, input string nm);
    int n; bit ok, held;
    @(posedge clk); #1;
    bpm = v;
    wait_upd(n, ok, held);
    chk({nm, " seen"}, {31'd0, ok}, 32'd1);
    chk({nm, " latency"}, n, 32'd10);
    chk({nm, " held"}, {31'd0, held}, 32'd1);
    chk({nm, " disp"}, disp_val, ed);
    chk({nm, " digits"}, {hundreds, tens, ones}, ed[11:0]);
    chk({nm, " blank"}, blank, eb);
    @(posedge clk); #1;
    chk({nm, " pulse1"}, {update, busy}, 32'd0);
  endtask

  initial begin
    int n; bit ok, held;
    int cnt;
    logic [7:0] cur, v;

    vecs[0] = '{8'd120, 16'h0120, 3'b000};
    vecs[1] = '{8'd255, 16'h0255, 3'b000};
    vecs[2] = '{8'd9,   16'h0009, 3'b110};
    vecs[3] = '{8'd47,  16'h0047, 3'b100};
    vecs[4] = '{8'd100, 16'h0100, 3'b000};
    vecs[5] = '{8'd10,  16'h0010, 3'b100};
    vecs[6] = '{8'd199, 16'h0199, 3'b000};
    vecs[7] = '{8'd0,   16'h0000, 3'b110};

    rst = 1'b1;
    bpm = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset disp", disp_val, 16'h0000);
    chk("reset blank", blank, 3'b110);
    chk("reset busy/upd", {busy, update}, 32'd0);

    // Release with bpm=0: the pending flag forces a conversion.
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel busy", {31'd0, busy}, 32'd1);
    n = 1;
    while (!update && n < 40) begin @(posedge clk); #1; n++; end
    chk("rel latency", n, 32'd10);
    chk("rel disp", disp_val, 16'h0000);
    chk("rel blank", blank, 3'b110);
    repeat (3) @(posedge clk);

    for (int i = 0; i < 8; i++) begin
      run_conv(vecs[i].bpm, vecs[i].disp, vecs[i].blank, $sformatf("vec%0d", i));
      if (i == 0) begin
        // Steady bpm produces no further conversions.
        cnt = 0;
        repeat (20) begin @(posedge clk); #1; if (update || busy) cnt++; end
        chk("steady quiet", cnt, 32'd0);
      end
    end

    // 60 -> 90 mid-conversion: 60 lands first, then 90 reconverts at once.
    @(posedge clk); #1;
    bpm = 8'd60;
    repeat (4) @(posedge clk);
    #1;
    bpm = 8'd90;
    wait_upd(n, ok, held);
    chk("b2b first", {15'd0, ok, disp_val}, {16'd1, 16'h0060});
    wait_upd(n, ok, held);
    chk("b2b second", {15'd0, ok, disp_val}, {16'd1, 16'h0090});
    chk("b2b latency", n, 32'd10);
    cnt = 0;
    repeat (20) begin @(posedge clk); #1; if (update) cnt++; end
    chk("b2b extra pulses", cnt, 32'd0);

    // Reset during CONVERT of 200.
    @(posedge clk); #1;
    bpm = 8'd200;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst disp", disp_val, 16'h0000);
    chk("midrst blank", blank, 3'b110);
    chk("midrst busy/upd", {busy, update}, 32'd0);
    rst = 1'b0;
    wait_upd(n, ok, held);
    chk("midrst seen", {31'd0, ok}, 32'd1);
    chk("midrst latency", n, 32'd10);
    chk("midrst disp2", disp_val, 16'h0200);
    chk("midrst blank2", blank, 3'b000);
    cur = 8'd200;
    repeat (3) @(posedge clk);

    // Randomized sweep against the decimal model.
    for (int k = 0; k < 40; k++) begin
      v = 8'($urandom_range(0, 255));
      if (v == cur) v = v + 8'd1;
      run_conv(v, ref_disp(int'(v)), ref_blank(int'(v)), $sformatf("rnd%0d", v));
      cur = v;
      repeat (2) @(posedge clk);
    end

    chk("busy&update overlap", both_hi, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
